// File: rtl/clock_period_meter.sv
// Measures period and high time of an asynchronous slow clock in clk cycles, with a sticky stall timeout.
// Results appear SYNC_STAGES+1 clk after the in_clk edge; no backpressure, so period_valid is a 1-cycle pulse.
module clock_period_meter #(
    parameter int               CNT_W       = 27,
    parameter int               SYNC_STAGES = 2,
    parameter logic [CNT_W-1:0] MAX_PERIOD  = '1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_clk,
    input  logic             enable,
    output logic             rise_tick,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_valid,
    output logic             timeout
);
    typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

    localparam logic [CNT_W-1:0] ONE = 1;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   s_d;
    logic                   rise;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       hcnt;

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_d;

    // Synchronizer keeps running while disabled so the edge detector is valid on re-enable.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= '0;
            s_d    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_clk};
            s_d    <= s;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            cnt          <= '0;
            hcnt         <= '0;
            rise_tick    <= 1'b0;
            period       <= '0;
            high_time    <= '0;
            period_valid <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            rise_tick    <= enable & rise;
            period_valid <= 1'b0;
            if (!enable) begin
                state   <= IDLE;
                cnt     <= '0;
                hcnt    <= '0;
                timeout <= 1'b0;
            end else begin
                case (state)
                    IDLE: state <= ARM;
                    ARM: begin
                        if (rise) begin
                            cnt   <= ONE;
                            hcnt  <= ONE;
                            state <= MEASURE;
                        end
                    end
                    MEASURE: begin
                        // A rise landing on the last allowed cycle is a valid period, not a timeout.
                        if (rise) begin
                            period       <= cnt;
                            high_time    <= hcnt;
                            period_valid <= 1'b1;
                            timeout      <= 1'b0;
                            cnt          <= ONE;
                            hcnt         <= ONE;
                        end else if (cnt == MAX_PERIOD) begin
                            timeout <= 1'b1;
                            state   <= ARM;
                        end else begin
                            cnt  <= cnt + ONE;
                            hcnt <= hcnt + {{(CNT_W-1){1'b0}}, s};
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_clock_period_meter.sv
// Directed bench for clock_period_meter with MAX_PERIOD reduced to 100 for timeout scenarios.
module tb_clock_period_meter;
    localparam int CNT_W = 27;

    logic             clk = 1'b0;
    logic             rstn;
    logic             in_clk;
    logic             enable;
    logic             rise_tick;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             period_valid;
    logic             timeout;

    int nvec = 0;
    int nerr = 0;

    clock_period_meter #(
        .CNT_W      (CNT_W),
        .SYNC_STAGES(2),
        .MAX_PERIOD (27'd100)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .in_clk      (in_clk),
        .enable      (enable),
        .rise_tick   (rise_tick),
        .period      (period),
        .high_time   (high_time),
        .period_valid(period_valid),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    // Drive in_clk for one clk cycle; outputs are sampled 1 time unit after the edge.
    task automatic tick(input logic v);
        in_clk = v;
        @(posedge clk);
        #1;
    endtask

    // Reset, enable, and let the synchronizer settle low; the DUT ends up in ARM.
    task automatic start();
        rstn   = 1'b0;
        enable = 1'b0;
        in_clk = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn   = 1'b1;
        enable = 1'b1;
        for (int k = 0; k < 4; k++) tick(1'b0);
    endtask

    task automatic test_reset();
        rstn   = 1'b0;
        enable = 1'b0;
        in_clk = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        nvec++;
        if ({rise_tick, period_valid, timeout} !== 3'b000) begin
            nerr++;
            $display("FAIL reset_flags got rt=%b pv=%b to=%b exp 000", rise_tick, period_valid, timeout);
        end
        nvec++;
        if (period !== '0 || high_time !== '0) begin
            nerr++;
            $display("FAIL reset_counts got period=%0d high=%0d exp 0/0", period, high_time);
        end
        rstn = 1'b1;
        for (int i = 0; i < 24; i++) begin
            tick((i % 8) < 4);
            nvec++;
            if (rise_tick !== 1'b0 || period_valid !== 1'b0 || timeout !== 1'b0) begin
                nerr++;
                $display("FAIL disabled_idle i=%0d got rt=%b pv=%b to=%b exp 000", i, rise_tick, period_valid, timeout);
            end
        end
    endtask

    task automatic test_steady_4_4();
        logic er, ev;
        start();
        for (int i = 0; i < 42; i++) begin
            tick(i < 40 && (i % 8) < 4);
            er = (i >= 2) && ((i - 2) % 8 == 0);
            ev = er && (i >= 10);
            nvec++;
            if (rise_tick !== er) begin
                nerr++;
                $display("FAIL t1_rise_tick i=%0d got %b exp %b", i, rise_tick, er);
            end
            nvec++;
            if (period_valid !== ev) begin
                nerr++;
                $display("FAIL t1_valid i=%0d got %b exp %b", i, period_valid, ev);
            end
            if (ev) begin
                nvec++;
                if (period !== 27'd8 || high_time !== 27'd4) begin
                    nerr++;
                    $display("FAIL t1_meas i=%0d got %0d/%0d exp 8/4", i, period, high_time);
                end
            end
        end
        nvec++;
        if (timeout !== 1'b0) begin
            nerr++;
            $display("FAIL t1_timeout got %b exp 0", timeout);
        end
    endtask

    task automatic test_duty_change();
        logic er, ev, v;
        int   e;
        start();
        for (int i = 0; i < 48; i++) begin
            v = (i < 24) ? ((i % 8) < 6) : (((i - 24) % 6) < 3);
            tick(v);
            e  = i - 2;
            er = (i >= 2) && ((e < 24) ? (e % 8 == 0) : ((e - 24) % 6 == 0));
            ev = er && (e >= 8);
            nvec++;
            if (period_valid !== ev) begin
                nerr++;
                $display("FAIL t2_valid i=%0d got %b exp %b", i, period_valid, ev);
            end
            if (ev) begin
                nvec++;
                if (e <= 24) begin
                    if (period !== 27'd8 || high_time !== 27'd6) begin
                        nerr++;
                        $display("FAIL t2_meas_6_2 i=%0d got %0d/%0d exp 8/6", i, period, high_time);
                    end
                end else begin
                    if (period !== 27'd6 || high_time !== 27'd3) begin
                        nerr++;
                        $display("FAIL t2_meas_3_3 i=%0d got %0d/%0d exp 6/3", i, period, high_time);
                    end
                end
            end
        end
        for (int k = 0; k < 3; k++) tick(1'b0);
    endtask

    task automatic test_timeout();
        logic eto, ev;
        start();
        for (int i = 0; i < 124; i++) begin
            tick(i < 4 || (i >= 110 && i < 114) || (i >= 118 && i < 122));
            eto = (i >= 102) && (i < 120);
            ev  = (i == 120);
            nvec++;
            if (timeout !== eto) begin
                nerr++;
                $display("FAIL t3_timeout i=%0d got %b exp %b", i, timeout, eto);
            end
            nvec++;
            if (period_valid !== ev) begin
                nerr++;
                $display("FAIL t3_valid i=%0d got %b exp %b", i, period_valid, ev);
            end
            if (ev) begin
                nvec++;
                if (period !== 27'd8 || high_time !== 27'd4) begin
                    nerr++;
                    $display("FAIL t3_meas i=%0d got %0d/%0d exp 8/4", i, period, high_time);
                end
            end
        end
    endtask

    task automatic test_max_period_boundary();
        logic ev;
        start();
        for (int i = 0; i < 206; i++) begin
            tick((i % 100) < 4);
            ev = (i == 102) || (i == 202);
            nvec++;
            if (timeout !== 1'b0) begin
                nerr++;
                $display("FAIL t4_timeout i=%0d got %b exp 0", i, timeout);
            end
            nvec++;
            if (period_valid !== ev) begin
                nerr++;
                $display("FAIL t4_valid i=%0d got %b exp %b", i, period_valid, ev);
            end
            if (ev) begin
                nvec++;
                if (period !== 27'd100 || high_time !== 27'd4) begin
                    nerr++;
                    $display("FAIL t4_meas i=%0d got %0d/%0d exp 100/4", i, period, high_time);
                end
            end
        end
    endtask

    task automatic test_enable_gap();
        logic er, ev;
        logic [CNT_W-1:0] ep;
        start();
        for (int i = 0; i < 38; i++) begin
            enable = !(i >= 17 && i <= 19);
            tick((i % 8) < 4);
            er = (i >= 2) && ((i - 2) % 8 == 0) && !(i >= 17 && i <= 19);
            ev = (i == 10) || (i == 34);
            ep = (i >= 10) ? 27'd8 : 27'd0;
            nvec++;
            if (rise_tick !== er) begin
                nerr++;
                $display("FAIL t5_rise_tick i=%0d got %b exp %b", i, rise_tick, er);
            end
            nvec++;
            if (period_valid !== ev) begin
                nerr++;
                $display("FAIL t5_valid i=%0d got %b exp %b", i, period_valid, ev);
            end
            nvec++;
            if (period !== ep) begin
                nerr++;
                $display("FAIL t5_period_hold i=%0d got %0d exp %0d", i, period, ep);
            end
        end
        enable = 1'b1;
    endtask

    task automatic test_reset_mid_measure();
        logic er, ev;
        start();
        for (int i = 0; i < 19; i++) tick((i % 8) < 4);
        nvec++;
        if (period_valid !== 1'b1 || rise_tick !== 1'b1 || period !== 27'd8) begin
            nerr++;
            $display("FAIL t6_pre got pv=%b rt=%b period=%0d exp 1/1/8", period_valid, rise_tick, period);
        end
        #2;
        rstn   = 1'b0;
        in_clk = 1'b0;
        #1;
        nvec++;
        if ({rise_tick, period_valid, timeout} !== 3'b000 || period !== '0 || high_time !== '0) begin
            nerr++;
            $display("FAIL t6_async_clear got rt=%b pv=%b to=%b period=%0d high=%0d exp all 0",
                     rise_tick, period_valid, timeout, period, high_time);
        end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int k = 0; k < 4; k++) tick(1'b0);
        for (int i = 0; i < 26; i++) begin
            tick(i < 24 && (i % 8) < 4);
            er = (i >= 2) && ((i - 2) % 8 == 0);
            ev = er && (i >= 10);
            nvec++;
            if (rise_tick !== er || period_valid !== ev) begin
                nerr++;
                $display("FAIL t6_restart i=%0d got rt=%b pv=%b exp %b/%b", i, rise_tick, period_valid, er, ev);
            end
            if (ev) begin
                nvec++;
                if (period !== 27'd8 || high_time !== 27'd4) begin
                    nerr++;
                    $display("FAIL t6_meas i=%0d got %0d/%0d exp 8/4", i, period, high_time);
                end
            end
        end
    endtask

    initial begin
        rstn   = 1'b0;
        enable = 1'b0;
        in_clk = 1'b0;
        test_reset();
        test_steady_4_4();
        test_duty_change();
        test_timeout();
        test_max_period_boundary();
        test_enable_gap();
        test_reset_mid_measure();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
